// File: rtl/xbtn_event_fifo.sv
// Button-event capture: per-button synchroniser and debouncer feeding a small press-mask FIFO
// that the CPU drains through EVENT reads and controls through STATUS writes.
module xbtn_event_fifo #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned DEPTH_LOG2      = 3,
   parameter int unsigned DATA_W          = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        btn,
   input  logic              sel,
   input  logic              addr,
   input  logic              rd_en,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              irq
);

   localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned Depth  = 1 << DEPTH_LOG2;
   localparam int unsigned CountW = DEPTH_LOG2 + 1;
   localparam logic [CntW-1:0]   CntMax    = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CountW-1:0] CountFull = CountW'(Depth);

   logic [3:0]            sync1_q, sync2_q;
   logic [3:0]            stable_q, stable_d, stable_prev_q;
   logic [CntW-1:0]       cnt_q [4];
   logic [CntW-1:0]       cnt_d [4];
   logic [3:0]            press;

   logic [3:0]            mem [Depth];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CountW-1:0]     count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  empty, full, status_wr, flush, ovf_clr, pop, push_req, do_push, do_pop;
   logic                  unused_data;

   assign unused_data = ^data_in[DATA_W-1:2];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         stable_q      <= '0;
         stable_prev_q <= '0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q       <= btn;
         sync2_q       <= sync1_q;
         stable_q      <= stable_d;
         stable_prev_q <= stable_q;
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Counter runs only while the synced value disagrees with the accepted one.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CntMax) stable_d[i] = sync2_q[i];
            else                    cnt_d[i]    = cnt_q[i] + 1'b1;
         end
      end
   end

   assign press = stable_q & ~stable_prev_q;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CountFull);
   assign status_wr = sel & wr_en & addr;
   assign flush     = status_wr & data_in[1];
   assign ovf_clr   = status_wr & data_in[0];
   assign pop       = sel & rd_en & ~addr & ~empty;
   assign push_req  = |press;
   // A flush discards both a same-cycle push and a same-cycle pop.
   assign do_push   = push_req & ~flush & (~full | pop);
   assign do_pop    = pop & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CountW'(do_push) - CountW'(do_pop);
      end
   end

   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (push_req && full && !pop && !flush) ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= press;
   end

   always_comb begin
      data_out = '0;
      if (sel) begin
         if (!addr) begin
            if (!empty) begin
               data_out[31]  = 1'b1;
               data_out[3:0] = mem[rd_ptr_q];
            end
         end else begin
            data_out[31]             = ~empty;
            data_out[30]             = full;
            data_out[29]             = ovf_q;
            data_out[8 +: CountW]    = count_q;
            data_out[3:0]            = stable_q;
         end
      end
   end

   assign irq = ~empty;

endmodule

// File: tb/tb_xbtn_event_fifo.sv
// Directed bench for xbtn_event_fifo with a short debounce window and an 8-entry FIFO.
module tb_xbtn_event_fifo;

   localparam int unsigned DB = 4;
   localparam int unsigned DL = 3;

   logic        clk = 1'b0;
   logic        rst, sel, addr, rd_en, wr_en, irq;
   logic [3:0]  btn;
   logic [31:0] data_in, data_out;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [3:0]  seq [9];

   xbtn_event_fifo #(
      .DEBOUNCE_CYCLES (DB),
      .DEPTH_LOG2      (DL),
      .DATA_W          (32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn      (btn),
      .sel      (sel),
      .addr     (addr),
      .rd_en    (rd_en),
      .wr_en    (wr_en),
      .data_in  (data_in),
      .data_out (data_out),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic peek(input logic a, input logic [31:0] exp, input string tag);
      sel   = 1'b1;
      addr  = a;
      rd_en = 1'b0;
      #1;
      check(tag, data_out, exp);
   endtask

   task automatic pop(input logic [31:0] exp, input string tag);
      sel   = 1'b1;
      addr  = 1'b0;
      rd_en = 1'b1;
      #1;
      check(tag, data_out, exp);
      @(posedge clk);
      #1;
      rd_en = 1'b0;
   endtask

   task automatic wr(input logic a, input logic [31:0] d);
      sel     = 1'b1;
      addr    = a;
      wr_en   = 1'b1;
      data_in = d;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      data_in = '0;
   endtask

   task automatic tap(input logic [3:0] m);
      btn = m;
      cycles(8);
      btn = 4'b0;
      cycles(8);
   endtask

   initial begin
      seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5, 4'h6, 4'h9, 4'hF};
      rst = 1'b1; sel = 1'b0; addr = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
      btn = 4'b0; data_in = '0;
      cycles(2);
      rst = 1'b0;
      cycles(1);
      check("reset_irq", {31'b0, irq}, 32'h0);
      peek(1'b0, 32'h0, "reset_event");
      peek(1'b1, 32'h0, "reset_status");

      // Single press on btn[2]: irq rises after E0+6.
      btn = 4'b0100;
      cycles(1);
      cycles(5);
      check("single_irq_early", {31'b0, irq}, 32'h0);
      cycles(1);
      check("single_irq_late", {31'b0, irq}, 32'h1);
      peek(1'b1, 32'h8000_0104, "single_status");
      pop(32'h8000_0004, "single_event");
      check("single_irq_after_pop", {31'b0, irq}, 32'h0);
      pop(32'h0, "single_pop_empty");
      btn = 4'b0;
      cycles(10);
      check("release_irq", {31'b0, irq}, 32'h0);
      peek(1'b1, 32'h0, "release_status");

      // Bounce on btn[0], then a steady hold.
      for (int k = 0; k < 4; k++) begin
         btn = 4'b0001;
         cycles(2);
         btn = 4'b0000;
         cycles(1);
      end
      btn = 4'b0001;
      cycles(1);
      cycles(5);
      check("bounce_irq_early", {31'b0, irq}, 32'h0);
      cycles(1);
      check("bounce_irq_late", {31'b0, irq}, 32'h1);
      pop(32'h8000_0001, "bounce_event");
      pop(32'h0, "bounce_only_one");
      btn = 4'b0;
      cycles(10);

      // Simultaneous presses on btn[1] and btn[3].
      btn = 4'b1010;
      cycles(10);
      peek(1'b1, 32'h8000_010A, "simul_status");
      pop(32'h8000_000A, "simul_event");
      btn = 4'b0;
      cycles(10);
      peek(1'b1, 32'h0, "simul_status_after");

      // Overflow: nine presses into eight slots.
      for (int i = 0; i < 9; i++) tap(seq[i]);
      peek(1'b1, 32'hE000_0800, "ovf_status");
      check("ovf_irq", {31'b0, irq}, 32'h1);
      for (int i = 0; i < 8; i++) pop({28'h800_0000, seq[i]}, $sformatf("drain_%0d", i));
      pop(32'h0, "drain_empty");
      peek(1'b1, 32'h2000_0000, "ovf_sticky");
      wr(1'b1, 32'h1);
      peek(1'b1, 32'h0, "ovf_cleared");

      // Fill, then pop on the same edge that pushes a new entry.
      for (int i = 0; i < 8; i++) tap(4'(1 << (i % 4)));
      peek(1'b1, 32'hC000_0800, "full_status");
      btn = 4'b0011;
      cycles(1);
      cycles(5);
      pop(32'h8000_0001, "pushpop_head");
      peek(1'b1, 32'hC000_0803, "pushpop_status");
      btn = 4'b0;
      cycles(10);
      for (int i = 0; i < 7; i++) pop({28'h800_0000, 4'(1 << ((i + 1) % 4))},
                                     $sformatf("pushpop_drain_%0d", i));
      pop(32'h8000_0003, "pushpop_new_tail");
      pop(32'h0, "pushpop_empty");

      // Select gating, ignored EVENT write, flush.
      tap(4'h1);
      tap(4'h2);
      check("flush_irq_before", {31'b0, irq}, 32'h1);
      sel = 1'b0;
      #1;
      check("sel_low", data_out, 32'h0);
      wr(1'b0, 32'h3);
      peek(1'b1, 32'h8000_0200, "event_write_ignored");
      wr(1'b1, 32'h2);
      check("flush_irq_after", {31'b0, irq}, 32'h0);
      peek(1'b1, 32'h0, "flush_status");

      // Reset mid-debounce restarts from a fresh press.
      btn = 4'b0100;
      cycles(3);
      rst = 1'b1;
      cycles(1);
      check("midrst_irq", {31'b0, irq}, 32'h0);
      peek(1'b1, 32'h0, "midrst_status");
      rst = 1'b0;
      cycles(1);
      cycles(5);
      check("midrst_irq_early", {31'b0, irq}, 32'h0);
      cycles(1);
      check("midrst_irq_late", {31'b0, irq}, 32'h1);
      pop(32'h8000_0004, "midrst_event");
      btn = 4'b0;
      cycles(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/xbtn_event_fifo.md
# xbtn_event_fifo

Button-event capture peripheral on the CPU parallel bus. Synchronises and debounces the four board push-buttons, turns each debounced press (0→1) into an event entry, and queues entries in a small FIFO that the CPU drains through reads. It is the input-direction counterpart of the LED/display write path: the external address decoder steers bus reads and writes to it through a select line, and it returns read data to the decoder's data mux.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles before a button change is accepted; ≥2.
- `DEPTH_LOG2`, 3: FIFO depth = 2^DEPTH_LOG2 entries (default 8).
- `DATA_W`, from `xdefs.vh` (32): bus data width.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `btn`  in  4  raw asynchronous push-buttons, active-high.
- `sel`  in  1  block selected by the external address decoder.
- `addr`  in  1  register select: 0 = EVENT, 1 = STATUS.
- `rd_en`  in  1  bus read strobe.
- `wr_en`  in  1  bus write strobe.
- `data_in`  in  DATA_W  bus write data.
- `data_out`  out  DATA_W  read data, combinational from `addr` and internal state.
- `irq`  out  1  high while FIFO is non-empty.

## Operation
- Synchroniser: 2 flops per button; reset value 0.
- Debounce, per button: `stable` bit (reset 0) and counter (reset 0, width ceil(log2(DEBOUNCE_CYCLES))). While synced ≠ stable, the counter increments; when it reaches DEBOUNCE_CYCLES−1 with the mismatch still present, `stable` takes the synced value and the counter clears. Any cycle with synced == stable clears the counter.
- Event: `press[i]` = stable[i] goes 0→1 this cycle. Releases generate no event. All presses accepted in the same cycle form one 4-bit mask entry.
- FIFO: push when mask ≠ 0. Pop when `sel & rd_en & addr==0` and FIFO non-empty.
- Push while full with no simultaneous pop: entry dropped, `ovf` sticky bit set.
- Push and pop in the same cycle, including when full: both happen; count unchanged; no overflow.
- Pop while empty: no state change.
- EVENT read (addr 0): bit 31 = non-empty, bits 3:0 = head mask; all other bits 0. When empty, the whole word is 0.
- STATUS read (addr 1, no pop): bit 31 = non-empty, bit 30 = full, bit 29 = `ovf`, bits [8+DEPTH_LOG2:8] = count, bits 3:0 = current `stable` vector.
- STATUS write (`sel & wr_en & addr==1`):
  - `data_in[0]=1`: clear `ovf`.
  - `data_in[1]=1`: flush FIFO (pointers and count to 0). A push in the same cycle is discarded.
- Writes to EVENT are ignored.
- `rd_en` and `wr_en` together: the read and write effects both apply, except that a flush overrides a pop.
- `data_out` = 0 when `sel` is low.
- Pointers wrap modulo 2^DEPTH_LOG2. Count is DEPTH_LOG2+1 bits, range 0..2^DEPTH_LOG2.

## Timing
- Reset (synchronous, effective at the clock edge with `rst`=1): sync flops, `stable`, counters, pointers, count and `ovf` all 0. `data_out`=0 and `irq`=0 from that edge. A reset asserted mid-debounce or mid-burst discards all pending state.
- Latency: raw `btn[i]` rises before edge E0 and stays high.
  - Synced value is visible after E0+1.
  - `stable[i]` is 1 after edge E0+1+DEBOUNCE_CYCLES.
  - The entry is pushed at the next edge, so `irq` and EVENT bit 31 are 1 after E0+2+DEBOUNCE_CYCLES.
- A bounce back to the stable value before the counter completes restarts the count. Pulses shorter than DEBOUNCE_CYCLES synced cycles produce no event.
- Pop takes effect at the edge that samples the read strobe. `data_out` shows the next head (or 0) after that edge. One pop per cycle that `rd_en` is high.

## Test plan
- Reset/idle: with `rst` high for 2 cycles and then released, and all buttons 0 → `data_out`=0 on both addresses, `irq`=0, STATUS count field 0.
- Single press, DEBOUNCE_CYCLES=4: raise `btn[2]` at E0 → `irq` rises after E0+6. EVENT read returns 0x80000004, then 0x00000000 on the next read. `irq` falls after the pop edge. Releasing the button adds no entry.
- Bounce rejection, DEBOUNCE_CYCLES=4: toggle `btn[0]` high 2 cycles / low 1 cycle repeatedly, then hold high → exactly one entry 0x80000001, timed from the final rising edge.
- Simultaneous presses: `btn[1]` and `btn[3]` rise on the same cycle → one entry 0x8000000A, count 1.
- Overflow, DEPTH_LOG2=3: 9 presses with no reads → STATUS = full, count 8, `ovf`=1. Draining returns exactly 8 entries in press order. A STATUS write of 0x1 clears `ovf`.
- Boundary cases:
  - Pop and push on the same cycle while full → count stays 8 and `ovf` stays 0.
  - Flush write → count 0 and `irq`=0 next cycle.
  - `rst` asserted mid-debounce → no event afterwards until a fresh, full-length press.
